// File: rtl/aes256_key_expand.sv
// Iterative AES-256 key expansion: one schedule word per clock into a 60-word
// register file, with a registered round-key read port.
module aes256_key_expand #(
  parameter int unsigned NR = 14,
  parameter int unsigned NK = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [32*NK-1:0]     key,
  output logic                 busy,
  output logic                 done,
  output logic                 key_valid,
  input  logic [3:0]           rd_round,
  output logic [127:0]         rd_key
);

  localparam int unsigned NW = 4 * (NR + 1);
  localparam int unsigned IW = 6;

  // Forward AES S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [31:0]   w [NW];

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  logic [31:0] prev;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [7:0]  rcon;
  logic [31:0] temp;
  logic [31:0] new_w;

  // Next schedule word from w[idx-1] and w[idx-8].
  always_comb begin
    prev    = w[IW'(idx - IW'(1))];
    sub_in  = (idx[2:0] == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    sub_out = sub_word(sub_in);
    rcon    = 8'h00;
    case (idx[5:3])
      3'd1:    rcon = 8'h01;
      3'd2:    rcon = 8'h02;
      3'd3:    rcon = 8'h04;
      3'd4:    rcon = 8'h08;
      3'd5:    rcon = 8'h10;
      3'd6:    rcon = 8'h20;
      3'd7:    rcon = 8'h40;
      default: rcon = 8'h00;
    endcase
    if (idx[2:0] == 3'd0)      temp = sub_out ^ {rcon, 24'h000000};
    else if (idx[2:0] == 3'd4) temp = sub_out;
    else                       temp = prev;
    new_w = w[IW'(idx - IW'(NK))] ^ temp;
  end

  // Register file: no reset; contents are only trusted while key_valid is set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == IDLE && start) begin
        for (int i = 0; i < int'(NK); i++) begin
          w[i] <= key[32*(int'(NK)-1-i) +: 32];
        end
      end else if (state == EXPAND) begin
        w[idx] <= new_w;
      end
    end
  end

  // Control FSM and registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      key_valid <= 1'b0;
      rd_key    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx       <= IW'(NK);
            busy      <= 1'b1;
            key_valid <= 1'b0;
            state     <= EXPAND;
          end
        end
        EXPAND: begin
          if (idx == IW'(NW - 1)) begin
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            key_valid <= 1'b1;
            state     <= IDLE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
      if (rd_round > 4'(NR)) begin
        rd_key <= '0;
      end else begin
        rd_key <= {w[{rd_round, 2'b00}], w[{rd_round, 2'b01}],
                   w[{rd_round, 2'b10}], w[{rd_round, 2'b11}]};
      end
    end
  end

endmodule

// File: tb/tb_aes256_key_expand.sv
// Bench for aes256_key_expand: FIPS-197 vectors plus a GF(2^8)-derived
// reference schedule, read back through a scoreboard queue.
module tb_aes256_key_expand;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] key;
  logic         busy;
  logic         done;
  logic         key_valid;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;

  aes256_key_expand dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key       (key),
    .busy      (busy),
    .done      (done),
    .key_valid (key_valid),
    .rd_round  (rd_round),
    .rd_key    (rd_key)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] KEY_A = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_B = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KEY_C = 256'hc47b0294dbbbee0fec4757f22ffeee3587ca4730c3d33b691df38bab076bc558;

  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  int t0       = 0;
  int busy_cnt = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] model_rk [15];
  logic [127:0] exp_q [$];
  logic [127:0] last_exp;
  bit           last_ok;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (busy) busy_cnt++;
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d = {v, v};
    return d[15-n -: 8];
  endfunction

  // S-box from first principles: multiplicative inverse then affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sbox_t[v[31:24]], sbox_t[v[23:16]], sbox_t[v[15:8]], sbox_t[v[7:0]]};
  endfunction

  task automatic expand_model(input logic [255:0] k);
    logic [31:0] mw [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 8; i++) mw[i] = k[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = mw[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      mw[i] = mw[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) model_rk[r] = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endtask

  task automatic start_key(input logic [255:0] k);
    key      = k;
    start    = 1'b1;
    busy_cnt = 0;
    last_ok  = 1'b0;
    tick();
    start = 1'b0;
    t0    = cyc;
  endtask

  // Waits (bounded) for done; expects it 52 edges after the accepting edge.
  task automatic wait_done(input string tag);
    int guard = 0;
    while (!done && guard < 100) begin
      tick();
      guard++;
    end
    check({tag, "_done_edge"}, done ? 128'(cyc - t0) : '1, 128'(52));
    check({tag, "_busy_cycles"}, 128'(busy_cnt), 128'(52));
    check({tag, "_valid_at_done"}, 128'(key_valid), 128'(1));
  endtask

  task automatic read_rk(input string tag, input int r, input logic [127:0] expv);
    rd_round = 4'(r);
    if (last_ok) check({tag, "_hold"}, rd_key, last_exp);
    exp_q.push_back(expv);
    tick();
    check(tag, rd_key, exp_q.pop_front());
    last_exp = expv;
    last_ok  = 1'b1;
  endtask

  task automatic read_all(input string tag);
    for (int r = 0; r < 15; r++) read_rk($sformatf("%s_rk%0d", tag, r), r, model_rk[r]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    rst      = 1'b1;
    start    = 1'b0;
    key      = '0;
    rd_round = 4'd0;
    last_ok  = 1'b0;
    build_sbox();
    tick();
    tick();
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_valid", 128'(key_valid), 128'(0));
    check("rst_rd_key", rd_key, '0);
    rst = 1'b0;

    // Test 1: FIPS-197 key, latency and first two round keys
    expand_model(KEY_A);
    start_key(KEY_A);
    check("t1_busy_after_accept", 128'(busy), 128'(1));
    check("t1_valid_after_accept", 128'(key_valid), 128'(0));
    wait_done("t1");
    tick();
    check("t1_done_one_cycle", 128'(done), 128'(0));
    check("t1_valid_level", 128'(key_valid), 128'(1));
    read_rk("t1_rk0", 0, 128'h000102030405060708090a0b0c0d0e0f);
    read_rk("t1_rk1", 1, 128'h101112131415161718191a1b1c1d1e1f);

    // Test 2: published later round keys, then the whole schedule
    read_rk("t2_rk2", 2, 128'ha573c29fa176c498a97fce93a572c09c);
    read_rk("t2_rk3", 3, 128'h1651a8cd0244beda1a5da4c10640bade);
    read_rk("t2_rk14", 14, 128'h24fc79ccbf0979e9371ac23c6d68de36);
    read_all("t2");

    // Test 3: start during expansion is ignored
    start_key(KEY_A);
    repeat (9) tick();
    key   = '1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t3_busy_ignored_start", 128'(busy), 128'(1));
    wait_done("t3");
    tick();
    read_rk("t3_rk2", 2, 128'ha573c29fa176c498a97fce93a572c09c);
    read_rk("t3_rk14", 14, 128'h24fc79ccbf0979e9371ac23c6d68de36);

    // Test 4: reset mid-expansion, taking priority over a simultaneous start
    start_key(KEY_A);
    while (cyc - t0 < 20) tick();
    rst   = 1'b1;
    start = 1'b1;
    key   = '1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("t4_busy", 128'(busy), 128'(0));
    check("t4_valid", 128'(key_valid), 128'(0));
    check("t4_rd_key", rd_key, '0);
    check("t4_done", 128'(done), 128'(0));
    dn = 0;
    repeat (60) begin
      tick();
      if (done || busy) dn++;
    end
    check("t4_no_activity", 128'(dn), 128'(0));
    start_key(KEY_A);
    wait_done("t4");
    tick();
    read_rk("t4_rk14", 14, 128'h24fc79ccbf0979e9371ac23c6d68de36);

    // Test 5: out-of-range read, then start in the done cycle
    read_rk("t5_rd15", 15, '0);
    expand_model(KEY_B);
    start_key(KEY_A);
    wait_done("t5a");
    start_key(KEY_B);
    check("t5_b2b_valid", 128'(key_valid), 128'(0));
    check("t5_b2b_done", 128'(done), 128'(0));
    check("t5_b2b_busy", 128'(busy), 128'(1));
    wait_done("t5b");
    tick();
    read_all("t5");

    // Test 6: new key over a valid schedule
    expand_model(KEY_C);
    check("t6_valid_before", 128'(key_valid), 128'(1));
    start_key(KEY_C);
    check("t6_valid_dropped", 128'(key_valid), 128'(0));
    wait_done("t6");
    tick();
    read_all("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
